// File: rtl/bellek_hakemi.sv
// bellek_hakemi: arbiter that lets the fetch port (l1b) and the data port
// (l1v) share one external memory bus. Only one bus transaction is
// outstanding at a time. Each core port sees a stall/value handshake.
module bellek_hakemi #(
  parameter int VERI_ONCELIKLI = 1,
  parameter int ZAMAN_ASIMI    = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        l1b_chip_select_n_i,
  input  logic [31:0] l1b_adres_i,
  output logic        l1b_bekle_o,
  output logic [31:0] l1b_deger_o,
  input  logic        l1v_chip_select_n_i,
  input  logic        l1v_yaz_i,
  input  logic [31:0] l1v_adres_i,
  input  logic [31:0] l1v_yaz_deger_i,
  input  logic [3:0]  l1v_yaz_maske_i,
  output logic        l1v_bekle_o,
  output logic [31:0] l1v_deger_o,
  output logic        bellek_gecerli_o,
  input  logic        bellek_hazir_i,
  output logic        bellek_yaz_o,
  output logic [31:0] bellek_adres_o,
  output logic [31:0] bellek_yaz_deger_o,
  output logic [3:0]  bellek_yaz_maske_o,
  input  logic        bellek_deger_gecerli_i,
  input  logic [31:0] bellek_deger_i,
  output logic        hata_o
);

  // The timeout limit lives in an 8-bit counter; a limit of zero turns it off.
  localparam logic [7:0] LP_ZAMAN        = 8'(ZAMAN_ASIMI);
  localparam logic       LP_VERI_ONCELIK = (VERI_ONCELIKLI != 0);

  typedef enum logic [1:0] {BOSTA, ISTEK, YANIT, TAMAM} durum_t;

  durum_t      r_durum;
  logic        r_sahip;
  logic        r_son_sahip;
  logic        r_gecerli;
  logic        r_yaz;
  logic        r_hata;
  logic [31:0] r_adres;
  logic [31:0] r_yaz_deger;
  logic [3:0]  r_maske;
  logic [31:0] r_l1b_deger;
  logic [31:0] r_l1v_deger;
  logic [7:0]  r_sayac;

  logic        w_l1b_ister;
  logic        w_l1v_ister;
  logic        w_kazanan;
  logic [7:0]  w_sayac_sonraki;
  logic        w_zaman_doldu;

  assign w_l1b_ister     = !l1b_chip_select_n_i;
  assign w_l1v_ister     = !l1v_chip_select_n_i;
  assign w_sayac_sonraki = r_sayac + 8'd1;
  assign w_zaman_doldu   = (LP_ZAMAN != 8'd0) && (w_sayac_sonraki == LP_ZAMAN);

  // Pick the winning port: a lone requester wins outright; on a tie the data
  // port wins under fixed priority, otherwise whichever port was not served last.
  always_comb begin
    w_kazanan = w_l1v_ister;
    if (w_l1b_ister && w_l1v_ister) begin
      w_kazanan = LP_VERI_ONCELIK ? 1'b1 : !r_son_sahip;
    end
  end

  // Transaction sequencer: grant in BOSTA, present on the bus in ISTEK, wait
  // for read data (or the timeout) in YANIT, release the owner for one cycle in TAMAM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum     <= BOSTA;
      r_sahip     <= 1'b0;
      r_son_sahip <= 1'b1;
      r_gecerli   <= 1'b0;
      r_yaz       <= 1'b0;
      r_hata      <= 1'b0;
      r_adres     <= 32'h0;
      r_yaz_deger <= 32'h0;
      r_maske     <= 4'b0000;
      r_l1b_deger <= 32'h0;
      r_l1v_deger <= 32'h0;
      r_sayac     <= 8'd0;
    end else begin
      r_hata <= 1'b0;
      case (r_durum)
        BOSTA: begin
          if (w_l1b_ister || w_l1v_ister) begin
            r_sahip     <= w_kazanan;
            r_son_sahip <= w_kazanan;
            r_gecerli   <= 1'b1;
            if (w_kazanan) begin
              r_yaz       <= l1v_yaz_i;
              r_adres     <= l1v_adres_i;
              r_yaz_deger <= l1v_yaz_deger_i;
              r_maske     <= l1v_yaz_i ? l1v_yaz_maske_i : 4'b0000;
            end else begin
              r_yaz       <= 1'b0;
              r_adres     <= l1b_adres_i;
              r_yaz_deger <= 32'h0;
              r_maske     <= 4'b0000;
            end
            r_durum <= ISTEK;
          end
        end
        ISTEK: begin
          if (bellek_hazir_i) begin
            r_gecerli <= 1'b0;
            if (r_yaz) begin
              r_durum <= TAMAM;
            end else begin
              r_sayac <= 8'd0;
              r_durum <= YANIT;
            end
          end
        end
        YANIT: begin
          if (bellek_deger_gecerli_i) begin
            if (r_sahip) r_l1v_deger <= bellek_deger_i;
            else         r_l1b_deger <= bellek_deger_i;
            r_durum <= TAMAM;
          end else if (w_zaman_doldu) begin
            if (r_sahip) r_l1v_deger <= 32'h0;
            else         r_l1b_deger <= 32'h0;
            r_hata  <= 1'b1;
            r_durum <= TAMAM;
          end else begin
            r_sayac <= w_sayac_sonraki;
          end
        end
        TAMAM: begin
          r_durum <= BOSTA;
        end
        default: begin
          r_durum <= BOSTA;
        end
      endcase
    end
  end

  assign l1b_bekle_o = w_l1b_ister && !((r_durum == TAMAM) && (r_sahip == 1'b0));
  assign l1v_bekle_o = w_l1v_ister && !((r_durum == TAMAM) && (r_sahip == 1'b1));

  assign l1b_deger_o        = r_l1b_deger;
  assign l1v_deger_o        = r_l1v_deger;
  assign bellek_gecerli_o   = r_gecerli;
  assign bellek_yaz_o       = r_yaz;
  assign bellek_adres_o     = r_adres;
  assign bellek_yaz_deger_o = r_yaz_deger;
  assign bellek_yaz_maske_o = r_maske;
  assign hata_o             = r_hata;

endmodule

// File: tb/tb_bellek_hakemi.sv
// Directed bench for bellek_hakemi. The main instance uses data-port priority
// and a 4-cycle timeout; a second instance uses round-robin with no timeout.
module tb_bellek_hakemi;

  logic        clock = 1'b0;
  logic        reset;
  logic        l1bCsN, l1vCsN, l1vYaz;
  logic [31:0] l1bAdres, l1vAdres, l1vYazDeger;
  logic [3:0]  l1vMaske;
  logic        hazir, degerGecerli;
  logic [31:0] degerIn;
  logic        hazirRr, degerGecerliRr;
  logic [31:0] degerInRr;

  logic        l1bBekle, l1vBekle, gecerli, yaz, hata;
  logic [31:0] l1bDeger, l1vDeger, adres, yazDeger;
  logic [3:0]  maske;

  logic        l1bBekleRr, l1vBekleRr, gecerliRr, yazRr, hataRr;
  logic [31:0] l1bDegerRr, l1vDegerRr, adresRr, yazDegerRr;
  logic [3:0]  maskeRr;

  int checks = 0;
  int failures = 0;

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  bellek_hakemi #(.VERI_ONCELIKLI(1), .ZAMAN_ASIMI(4)) dut (
    .clk_i(clock), .rst_i(reset),
    .l1b_chip_select_n_i(l1bCsN), .l1b_adres_i(l1bAdres),
    .l1b_bekle_o(l1bBekle), .l1b_deger_o(l1bDeger),
    .l1v_chip_select_n_i(l1vCsN), .l1v_yaz_i(l1vYaz), .l1v_adres_i(l1vAdres),
    .l1v_yaz_deger_i(l1vYazDeger), .l1v_yaz_maske_i(l1vMaske),
    .l1v_bekle_o(l1vBekle), .l1v_deger_o(l1vDeger),
    .bellek_gecerli_o(gecerli), .bellek_hazir_i(hazir), .bellek_yaz_o(yaz),
    .bellek_adres_o(adres), .bellek_yaz_deger_o(yazDeger), .bellek_yaz_maske_o(maske),
    .bellek_deger_gecerli_i(degerGecerli), .bellek_deger_i(degerIn), .hata_o(hata)
  );

  bellek_hakemi #(.VERI_ONCELIKLI(0), .ZAMAN_ASIMI(0)) dutRr (
    .clk_i(clock), .rst_i(reset),
    .l1b_chip_select_n_i(l1bCsN), .l1b_adres_i(l1bAdres),
    .l1b_bekle_o(l1bBekleRr), .l1b_deger_o(l1bDegerRr),
    .l1v_chip_select_n_i(l1vCsN), .l1v_yaz_i(l1vYaz), .l1v_adres_i(l1vAdres),
    .l1v_yaz_deger_i(l1vYazDeger), .l1v_yaz_maske_i(l1vMaske),
    .l1v_bekle_o(l1vBekleRr), .l1v_deger_o(l1vDegerRr),
    .bellek_gecerli_o(gecerliRr), .bellek_hazir_i(hazirRr), .bellek_yaz_o(yazRr),
    .bellek_adres_o(adresRr), .bellek_yaz_deger_o(yazDegerRr), .bellek_yaz_maske_o(maskeRr),
    .bellek_deger_gecerli_i(degerGecerliRr), .bellek_deger_i(degerInRr), .hata_o(hataRr)
  );

  // Single comparison point: count it and report any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Drive all core and bus inputs to their idle values.
  task automatic applyStimulus();
    l1bCsN = 1'b1; l1vCsN = 1'b1; l1vYaz = 1'b0;
    l1bAdres = 32'h0; l1vAdres = 32'h0; l1vYazDeger = 32'h0; l1vMaske = 4'b0000;
    hazir = 1'b0; degerGecerli = 1'b0; degerIn = 32'h0;
  endtask

  // One read on the main instance over a zero-wait bus: stall 1,1,1,0 and the
  // returned word visible in the completion cycle.
  task automatic runRead(input logic isData, input logic [31:0] a, input logic [31:0] v, input string tag);
    if (isData) begin l1vCsN = 1'b0; l1vYaz = 1'b0; l1vAdres = a; end
    else        begin l1bCsN = 1'b0; l1bAdres = a; end
    #1 checkOutput({tag, "_c0_bekle"}, 32'(isData ? l1vBekle : l1bBekle), 32'd1);
    nextCycle();
    hazir = 1'b1;
    #1 checkOutput({tag, "_c1_gecerli"}, 32'(gecerli), 32'd1);
    checkOutput({tag, "_c1_adres"}, adres, a);
    checkOutput({tag, "_c1_maske"}, 32'(maske), 32'd0);
    checkOutput({tag, "_c1_yaz"}, 32'(yaz), 32'd0);
    checkOutput({tag, "_c1_bekle"}, 32'(isData ? l1vBekle : l1bBekle), 32'd1);
    nextCycle();
    hazir = 1'b0; degerGecerli = 1'b1; degerIn = v;
    #1 checkOutput({tag, "_c2_bekle"}, 32'(isData ? l1vBekle : l1bBekle), 32'd1);
    nextCycle();
    degerGecerli = 1'b0;
    #1 checkOutput({tag, "_c3_bekle"}, 32'(isData ? l1vBekle : l1bBekle), 32'd0);
    checkOutput({tag, "_c3_deger"}, isData ? l1vDeger : l1bDeger, v);
    nextCycle();
    l1bCsN = 1'b1; l1vCsN = 1'b1;
  endtask

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] grants [4];
    int          nGrants;
    logic        prevG;

    applyStimulus();
    hazirRr = 1'b1; degerGecerliRr = 1'b1; degerInRr = 32'h0;
    reset = 1'b1;
    repeat (3) nextCycle();
    checkOutput("rst_gecerli", 32'(gecerli), 32'd0);
    checkOutput("rst_yaz", 32'(yaz), 32'd0);
    checkOutput("rst_hata", 32'(hata), 32'd0);
    checkOutput("rst_adres", adres, 32'h0);
    checkOutput("rst_yazDeger", yazDeger, 32'h0);
    checkOutput("rst_maske", 32'(maske), 32'd0);
    checkOutput("rst_l1bDeger", l1bDeger, 32'h0);
    checkOutput("rst_l1vDeger", l1vDeger, 32'h0);
    checkOutput("rst_bekle", {30'd0, l1bBekle, l1vBekle}, 32'd0);
    reset = 1'b0;
    nextCycle();

    // Lone fetch read.
    runRead(1'b0, 32'h0000_0100, 32'hDEAD_BEEF, "fetch");

    // Tie: data write goes first, fetch waits then follows.
    l1bCsN = 1'b0; l1bAdres = 32'h200;
    l1vCsN = 1'b0; l1vYaz = 1'b1; l1vAdres = 32'h1000; l1vYazDeger = 32'h1234_5678; l1vMaske = 4'b0011;
    #1 checkOutput("tie_c0_l1bBekle", 32'(l1bBekle), 32'd1);
    checkOutput("tie_c0_l1vBekle", 32'(l1vBekle), 32'd1);
    nextCycle();
    hazir = 1'b1;
    #1 checkOutput("tie_c1_yaz", 32'(yaz), 32'd1);
    checkOutput("tie_c1_adres", adres, 32'h1000);
    checkOutput("tie_c1_yazDeger", yazDeger, 32'h1234_5678);
    checkOutput("tie_c1_maske", 32'(maske), 32'h3);
    checkOutput("tie_c1_l1bBekle", 32'(l1bBekle), 32'd1);
    nextCycle();
    hazir = 1'b0;
    #1 checkOutput("tie_c2_l1vBekle", 32'(l1vBekle), 32'd0);
    checkOutput("tie_c2_l1bBekle", 32'(l1bBekle), 32'd1);
    checkOutput("tie_c2_gecerli", 32'(gecerli), 32'd0);
    nextCycle();
    l1vCsN = 1'b1; l1vYaz = 1'b0;
    #1 checkOutput("tie_c3_l1bBekle", 32'(l1bBekle), 32'd1);
    nextCycle();
    hazir = 1'b1;
    #1 checkOutput("tie_c4_gecerli", 32'(gecerli), 32'd1);
    checkOutput("tie_c4_adres", adres, 32'h200);
    checkOutput("tie_c4_maske", 32'(maske), 32'd0);
    checkOutput("tie_c4_yaz", 32'(yaz), 32'd0);
    checkOutput("tie_c4_l1bBekle", 32'(l1bBekle), 32'd1);
    nextCycle();
    hazir = 1'b0; degerGecerli = 1'b1; degerIn = 32'hCAFE_0001;
    #1 checkOutput("tie_c5_l1bBekle", 32'(l1bBekle), 32'd1);
    nextCycle();
    degerGecerli = 1'b0;
    #1 checkOutput("tie_c6_l1bBekle", 32'(l1bBekle), 32'd0);
    checkOutput("tie_c6_l1bDeger", l1bDeger, 32'hCAFE_0001);
    checkOutput("tie_c6_l1vDeger", l1vDeger, 32'h0);
    nextCycle();
    l1bCsN = 1'b1;

    // Round-robin instance: both ports request continuously.
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    l1bCsN = 1'b0; l1bAdres = 32'hB0;
    l1vCsN = 1'b0; l1vYaz = 1'b0; l1vAdres = 32'hF0;
    nGrants = 0;
    prevG = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (gecerliRr && !prevG && nGrants < 4) begin
        grants[nGrants] = adresRr;
        nGrants++;
      end
      prevG = gecerliRr;
      nextCycle();
    end
    checkOutput("rr_grantCount", 32'(nGrants), 32'd4);
    checkOutput("rr_grant0", grants[0], 32'hB0);
    checkOutput("rr_grant1", grants[1], 32'hF0);
    checkOutput("rr_grant2", grants[2], 32'hB0);
    checkOutput("rr_grant3", grants[3], 32'hF0);
    applyStimulus();

    // Bus stall: held fields stay put while the core inputs change.
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    l1vCsN = 1'b0; l1vYaz = 1'b1; l1vAdres = 32'h3000; l1vYazDeger = 32'hA5A5_0F0F; l1vMaske = 4'b1100;
    nextCycle();
    l1vAdres = 32'hFFFF_0000; l1vYazDeger = 32'h0; l1vMaske = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1 checkOutput($sformatf("stall_%0d_gecerli", i), 32'(gecerli), 32'd1);
      checkOutput($sformatf("stall_%0d_adres", i), adres, 32'h3000);
      checkOutput($sformatf("stall_%0d_yazDeger", i), yazDeger, 32'hA5A5_0F0F);
      checkOutput($sformatf("stall_%0d_maske", i), 32'(maske), 32'hC);
      checkOutput($sformatf("stall_%0d_l1vBekle", i), 32'(l1vBekle), 32'd1);
      nextCycle();
    end
    hazir = 1'b1;
    #1 checkOutput("stall_accept_gecerli", 32'(gecerli), 32'd1);
    nextCycle();
    hazir = 1'b0;
    #1 checkOutput("stall_done_l1vBekle", 32'(l1vBekle), 32'd0);
    checkOutput("stall_done_gecerli", 32'(gecerli), 32'd0);
    nextCycle();
    applyStimulus();

    // Data read to load a nonzero value, then a read that times out.
    runRead(1'b1, 32'h2000, 32'h1111_2222, "dataRead");
    l1vCsN = 1'b0; l1vYaz = 1'b0; l1vAdres = 32'h4000;
    nextCycle();
    hazir = 1'b1;
    nextCycle();
    hazir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 checkOutput($sformatf("tmo_wait%0d_bekle", i), 32'(l1vBekle), 32'd1);
      checkOutput($sformatf("tmo_wait%0d_hata", i), 32'(hata), 32'd0);
      nextCycle();
    end
    #1 checkOutput("tmo_hata", 32'(hata), 32'd1);
    checkOutput("tmo_bekle", 32'(l1vBekle), 32'd0);
    checkOutput("tmo_deger", l1vDeger, 32'h0);
    nextCycle();
    l1vCsN = 1'b1;
    #1 checkOutput("tmo_hataPulse", 32'(hata), 32'd0);
    runRead(1'b0, 32'h500, 32'h5555_AAAA, "afterTimeout");

    // Reset during YANIT, then a stray response in BOSTA.
    l1vCsN = 1'b0; l1vYaz = 1'b0; l1vAdres = 32'h6000;
    nextCycle();
    hazir = 1'b1;
    nextCycle();
    hazir = 1'b0; reset = 1'b1; l1vCsN = 1'b1;
    nextCycle();
    reset = 1'b0; degerGecerli = 1'b1; degerIn = 32'hBAD0_BAD0;
    #1 checkOutput("rstMid_gecerli", 32'(gecerli), 32'd0);
    checkOutput("rstMid_adres", adres, 32'h0);
    checkOutput("rstMid_l1vDeger", l1vDeger, 32'h0);
    checkOutput("rstMid_l1bDeger", l1bDeger, 32'h0);
    nextCycle();
    degerGecerli = 1'b0;
    #1 checkOutput("stray_l1vDeger", l1vDeger, 32'h0);
    checkOutput("stray_gecerli", 32'(gecerli), 32'd0);
    checkOutput("stray_hata", 32'(hata), 32'd0);
    checkOutput("stray_bekle", {30'd0, l1bBekle, l1vBekle}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bellek_hakemi.md
# bellek_hakemi

Two-port memory arbiter between the core's instruction-fetch port (l1b) and data-access port (l1v), sharing one external memory bus. It sits directly outside the core, next to the fetch and memory stages. It serialises requests, with at most one transaction outstanding on the bus. Each core port sees its usual stall/value handshake: `bekle` high means stall, and `bekle` low with the request still asserted means `deger` is valid this cycle.

## Interface
- VERI_ONCELIKLI, 1: 1 = data port has fixed priority on a tie; 0 = round-robin on a tie.
- ZAMAN_ASIMI, 255: maximum cycles spent in YANIT before a forced completion; 0 disables the timeout. 8-bit counter.

- clk_i  input  1  clock
- rst_i  input  1  synchronous, active-high reset
- l1b_chip_select_n_i  input  1  fetch request, active low
- l1b_adres_i  input  32  fetch address
- l1b_bekle_o  output  1  fetch stall
- l1b_deger_o  output  32  fetch read data
- l1v_chip_select_n_i  input  1  data request, active low
- l1v_yaz_i  input  1  1 = write, 0 = read
- l1v_adres_i  input  32  data address
- l1v_yaz_deger_i  input  32  write data
- l1v_yaz_maske_i  input  4  byte-write mask
- l1v_bekle_o  output  1  data stall
- l1v_deger_o  output  32  data read data
- bellek_gecerli_o  output  1  bus request valid
- bellek_hazir_i  input  1  bus accepts the request
- bellek_yaz_o  output  1  bus write
- bellek_adres_o  output  32  bus address
- bellek_yaz_deger_o  output  32  bus write data
- bellek_yaz_maske_o  output  4  bus byte mask; 4'b0000 on reads
- bellek_deger_gecerli_i  input  1  read response valid
- bellek_deger_i  input  32  read response data
- hata_o  output  1  one-cycle pulse on timeout

## Operation

**FSM states:** BOSTA, ISTEK, YANIT, TAMAM. `sahip` is a 1-bit register holding the owning port (0 = l1b, 1 = l1v).

**BOSTA**
- Samples both requests.
- If any request is present: latch the winner's address, write flag, write data and mask into bus registers; set `sahip`; go to ISTEK.
- Tie with VERI_ONCELIKLI=1: l1v wins.
- Tie with VERI_ONCELIKLI=0: the port not granted last wins. The `son_sahip` register resets to 1, so l1b wins the first tie.

**ISTEK**
- `bellek_gecerli_o` = 1 and the bus registers are held stable until `bellek_hazir_i`.
- On accept: a write goes to TAMAM; a read goes to YANIT and clears the timeout counter.

**YANIT**
- On `bellek_deger_gecerli_i`: latch `bellek_deger_i` into the owner's `deger` register and go to TAMAM.
- Otherwise increment the counter.
- If ZAMAN_ASIMI ≠ 0 and the counter reaches ZAMAN_ASIMI: load `deger` = 32'h0, pulse `hata_o`, go to TAMAM.

**TAMAM**
- Lasts exactly one cycle, then BOSTA.
- The owner's `bekle_o` is 0; `deger_o` holds the read data (unchanged on a write).

**Stall outputs (combinational)**
- `l1b_bekle_o` = !l1b_chip_select_n_i && !(TAMAM && sahip==0)
- `l1v_bekle_o` = !l1v_chip_select_n_i && !(TAMAM && sahip==1)
- A non-requesting port sees `bekle` = 0.

**Boundary rules**
- Requester withdraws mid-transaction (e.g. a fetch flush): the bus transaction still completes. The response is captured but has no architectural effect, and no port is updated differently.
- The loser of arbitration keeps `bekle` = 1 and is granted in the BOSTA cycle after TAMAM.
- `bellek_deger_gecerli_i` outside YANIT is ignored.
- `bellek_hazir_i` outside ISTEK is ignored.
- Reset mid-transaction: go to BOSTA. Any late response after reset is ignored.

## Timing
- Reset values:
  - state BOSTA
  - `bellek_gecerli_o`, `bellek_yaz_o`, `hata_o` = 0
  - `bellek_adres_o`, `bellek_yaz_deger_o` = 0; `bellek_yaz_maske_o` = 0
  - `l1b_deger_o`, `l1v_deger_o` = 0
  - `sahip` = 0, `son_sahip` = 1, counter = 0
- All bus outputs are registered.
- Read, zero-wait bus: request seen in BOSTA at cycle 0 → ISTEK at cycle 1 (`gecerli`=1, `hazir`=1) → YANIT at cycle 2 (response arrives) → TAMAM at cycle 3. `bekle` = 1 in cycles 0–2 and 0 in cycle 3.
- Write, zero-wait bus: BOSTA (0) → ISTEK (1) → TAMAM (2).
- Back-to-back: the next grant is evaluated in BOSTA, one cycle after TAMAM. Minimum spacing is 4 cycles for reads and 3 for writes.
- Timeout: `hata_o` is high in the first TAMAM cycle only.

## Test plan
- Lone fetch read at 0x0000_0100; bus accepts at once and returns 0xDEAD_BEEF one cycle later → `l1b_bekle_o` 1,1,1,0; `l1b_deger_o` = 0xDEAD_BEEF in cycle 3; `bellek_yaz_maske_o` = 0.
- Simultaneous requests: fetch 0x200, data write 0x1000, data 0x1234_5678, mask 4'b0011; VERI_ONCELIKLI=1 → write is issued first with mask 0011; fetch is issued on the cycle after TAMAM; `l1b_bekle_o` stays 1 throughout.
- VERI_ONCELIKLI=0, both ports requesting continuously for 4 transactions → grant order l1b, l1v, l1b, l1v.
- `bellek_hazir_i` held low for 5 cycles → `bellek_gecerli_o` and all bus fields are stable for 5 cycles; completion follows acceptance as specified.
- ZAMAN_ASIMI=4, no read response → after 4 YANIT cycles: TAMAM, `deger_o` = 0, `hata_o` high for 1 cycle, next request is served normally.
- `rst_i` asserted in YANIT, then `bellek_deger_gecerli_i` pulsed in BOSTA → all outputs at reset values; the stray response is ignored; `deger_o` remains 0.
